tdm_demux_1xn: RTL and testbench

//  Time-division demultiplexer: receiver end of the mux-based slot serializer.

---
 rtl/tdm_demux_1xn_if.sv | 36 +++
 rtl/tdm_demux_1xn.sv | 129 ++++++++++++
 tb/tb_tdm_demux_1xn.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/tdm_demux_1xn_if.sv
// Shared-lane TDM bus between the serial link and the demux; parity signals exist only
// when TDM_DEMUX_PARITY_EN is defined.
interface tdm_demux_1xn_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
);
  logic [WIDTH-1:0]          din;
  logic                      din_valid;
  logic                      frame_sync;
  logic [CHANNELS*WIDTH-1:0] ch_data;
  logic [CHANNELS-1:0]       ch_valid;
  logic                      frame_done;
  logic                      sync_err;
`ifdef TDM_DEMUX_PARITY_EN
  logic                      din_par;
  logic                      par_err;
`endif

  modport master (
    output din, din_valid, frame_sync,
    input  ch_data, ch_valid, frame_done, sync_err
`ifdef TDM_DEMUX_PARITY_EN
    , output din_par
    , input  par_err
`endif
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output ch_data, ch_valid, frame_done, sync_err
`ifdef TDM_DEMUX_PARITY_EN
    , input  din_par
    , output par_err
`endif
  );
endinterface

// File: rtl/tdm_demux_1xn.sv
// TDM receiver: tracks slot position from frame_sync and steers each word to a registered
// per-channel output. Optional odd-parity check enabled by TDM_DEMUX_PARITY_EN.
module tdm_demux_1xn #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
) (
  input logic            clk,
  input logic            rst_n,
  tdm_demux_1xn_if.slave bus
);
  localparam int                SLOT_W    = $clog2(CHANNELS);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(CHANNELS - 1);

  typedef enum logic {HUNT, RECV} state_t;

  state_t              r_state, w_state_nxt;
  logic [SLOT_W-1:0]   r_slot, w_slot_nxt, w_wr_slot;
  logic                w_wr, w_wr_ok, w_done, w_serr, w_par_ok;

  logic [CHANNELS*WIDTH-1:0] r_ch_data_p1;
  logic [CHANNELS-1:0]       r_ch_valid_p1;
  logic                      r_frame_done_p1;
  logic                      r_sync_err_p1;

`ifdef TDM_DEMUX_PARITY_EN
  logic w_perr;
  logic r_par_err_p1;

  function automatic logic odd_par_ok(input logic [WIDTH-1:0] d, input logic p);
    return ^{d, p};
  endfunction

  assign w_par_ok = odd_par_ok(bus.din, bus.din_par);
  // Only words that would otherwise be written can raise a parity error.
  assign w_perr   = w_wr & ~w_par_ok;
`else
  assign w_par_ok = 1'b1;
`endif

  assign w_wr_ok = w_wr & w_par_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HUNT;
      r_slot  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_slot  <= w_slot_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_wr        = 1'b0;
    w_wr_slot   = '0;
    w_done      = 1'b0;
    w_serr      = 1'b0;
    if (bus.din_valid) begin
      unique case (r_state)
        HUNT: begin
          if (bus.frame_sync) begin
            w_wr        = 1'b1;
            w_slot_nxt  = SLOT_W'(1);
            w_state_nxt = RECV;
          end
        end
        RECV: begin
          if (r_slot == '0) begin
            if (bus.frame_sync) begin
              w_wr       = 1'b1;
              w_slot_nxt = SLOT_W'(1);
            end else begin
              w_serr      = 1'b1;
              w_state_nxt = HUNT;
            end
          end else if (bus.frame_sync) begin
            // Early sync: abandon the partial frame and restart on this word.
            w_serr     = 1'b1;
            w_wr       = 1'b1;
            w_slot_nxt = SLOT_W'(1);
          end else begin
            w_wr      = 1'b1;
            w_wr_slot = r_slot;
            if (r_slot == LAST_SLOT) begin
              w_done     = 1'b1;
              w_slot_nxt = '0;
            end else begin
              w_slot_nxt = r_slot + SLOT_W'(1);
            end
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  // Output stage p1: registered channel words and one-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch_data_p1    <= '0;
      r_ch_valid_p1   <= '0;
      r_frame_done_p1 <= 1'b0;
      r_sync_err_p1   <= 1'b0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        r_ch_valid_p1[k] <= w_wr_ok && (w_wr_slot == SLOT_W'(k));
        if (w_wr_ok && (w_wr_slot == SLOT_W'(k)))
          r_ch_data_p1[k*WIDTH +: WIDTH] <= bus.din;
      end
      r_frame_done_p1 <= w_done;
      r_sync_err_p1   <= w_serr;
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_par_err_p1 <= 1'b0;
    else        r_par_err_p1 <= w_perr;
  end

  assign bus.par_err = r_par_err_p1;
`endif

  assign bus.ch_data    = r_ch_data_p1;
  assign bus.ch_valid   = r_ch_valid_p1;
  assign bus.frame_done = r_frame_done_p1;
  assign bus.sync_err   = r_sync_err_p1;
endmodule

// File: tb/tb_tdm_demux_1xn.sv
// Directed bench for tdm_demux_1xn (CHANNELS=4, WIDTH=8); parity steps run only
// when TDM_DEMUX_PARITY_EN is defined.
module tb_tdm_demux_1xn;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  tdm_demux_1xn_if #(.CHANNELS(4), .WIDTH(8)) bus ();

  tdm_demux_1xn #(.CHANNELS(4), .WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] ev, input logic ed,
                         input logic es, input logic ep, input logic [31:0] edata);
    chk({tag, ".ch_valid"},   32'(bus.ch_valid),   32'(ev));
    chk({tag, ".frame_done"}, 32'(bus.frame_done), 32'(ed));
    chk({tag, ".sync_err"},   32'(bus.sync_err),   32'(es));
    chk({tag, ".ch_data"},    bus.ch_data,         edata);
`ifdef TDM_DEMUX_PARITY_EN
    chk({tag, ".par_err"},    32'(bus.par_err),    32'(ep));
`else
    if (ep) chk({tag, ".par_err_unbuilt"}, 32'(ep), 32'(1'b0));
`endif
  endtask

  // One bus cycle: drive at negedge, sample 1ns after the rising edge.
  task automatic step(input string tag, input logic v, input logic fs, input logic [7:0] d,
                      input logic bad_par, input logic [3:0] ev, input logic ed,
                      input logic es, input logic ep, input logic [31:0] edata);
    @(negedge clk);
    bus.din_valid  = v;
    bus.frame_sync = fs;
    bus.din        = d;
`ifdef TDM_DEMUX_PARITY_EN
    bus.din_par    = ~(^d) ^ bad_par;
`endif
    @(posedge clk);
    #1;
    chk_all(tag, ev, ed, es, ep, edata);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.din        = '0;
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    bus.din_par    = 1'b1;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 4'b0000, 0, 0, 0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++)
      step("idle", 0, 0, 8'h5A, 0, 4'b0000, 0, 0, 0, 32'h0);

    // HUNT drop, then first frame.
    step("hunt_aa", 1, 0, 8'hAA, 0, 4'b0000, 0, 0, 0, 32'h0);
    step("hunt_bb", 1, 0, 8'hBB, 0, 4'b0000, 0, 0, 0, 32'h0);
    step("f1_s0",   1, 1, 8'h01, 0, 4'b0001, 0, 0, 0, 32'h00000001);
    step("f1_s1",   1, 0, 8'h02, 0, 4'b0010, 0, 0, 0, 32'h00000201);
    step("f1_s2",   1, 0, 8'h03, 0, 4'b0100, 0, 0, 0, 32'h00030201);
    step("f1_s3",   1, 0, 8'h04, 0, 4'b1000, 1, 0, 0, 32'h04030201);

    // Clean back-to-back frame.
    step("f2_s0", 1, 1, 8'h11, 0, 4'b0001, 0, 0, 0, 32'h04030211);
    step("f2_s1", 1, 0, 8'h22, 0, 4'b0010, 0, 0, 0, 32'h04032211);
    step("f2_s2", 1, 0, 8'h33, 0, 4'b0100, 0, 0, 0, 32'h04332211);
    step("f2_s3", 1, 0, 8'h44, 0, 4'b1000, 1, 0, 0, 32'h44332211);

    // Early sync on the third word.
    step("es_10", 1, 1, 8'h10, 0, 4'b0001, 0, 0, 0, 32'h44332210);
    step("es_20", 1, 0, 8'h20, 0, 4'b0010, 0, 0, 0, 32'h44332010);
    step("es_30", 1, 1, 8'h30, 0, 4'b0001, 0, 1, 0, 32'h44332030);
    step("es_40", 1, 0, 8'h40, 0, 4'b0010, 0, 0, 0, 32'h44334030);
    step("es_50", 1, 0, 8'h50, 0, 4'b0100, 0, 0, 0, 32'h44504030);
    step("es_60", 1, 0, 8'h60, 0, 4'b1000, 1, 0, 0, 32'h60504030);

    // Frame with idle gaps, then missing sync.
    step("gp_01",  1, 1, 8'h01, 0, 4'b0001, 0, 0, 0, 32'h60504001);
    step("gp_id0", 0, 0, 8'hFF, 0, 4'b0000, 0, 0, 0, 32'h60504001);
    step("gp_02",  1, 0, 8'h02, 0, 4'b0010, 0, 0, 0, 32'h60500201);
    step("gp_id1", 0, 1, 8'hFF, 0, 4'b0000, 0, 0, 0, 32'h60500201);
    step("gp_03",  1, 0, 8'h03, 0, 4'b0100, 0, 0, 0, 32'h60030201);
    step("gp_id2", 0, 0, 8'hFF, 0, 4'b0000, 0, 0, 0, 32'h60030201);
    step("gp_04",  1, 0, 8'h04, 0, 4'b1000, 1, 0, 0, 32'h04030201);
    step("gp_id3", 0, 0, 8'hFF, 0, 4'b0000, 0, 0, 0, 32'h04030201);
    step("ms_99",  1, 0, 8'h99, 0, 4'b0000, 0, 1, 0, 32'h04030201);
    step("ms_hunt",1, 0, 8'h77, 0, 4'b0000, 0, 0, 0, 32'h04030201);

    // Async reset mid-frame.
    step("ar_ab", 1, 1, 8'hAB, 0, 4'b0001, 0, 0, 0, 32'h040302AB);
    step("ar_cd", 1, 0, 8'hCD, 0, 4'b0010, 0, 0, 0, 32'h0403CDAB);
    @(negedge clk);
    bus.din_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk_all("ar_async", 4'b0000, 0, 0, 0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step("ar_hunt", 1, 0, 8'hEE, 0, 4'b0000, 0, 0, 0, 32'h0);
    step("f3_s0",   1, 1, 8'hA1, 0, 4'b0001, 0, 0, 0, 32'h000000A1);
    step("f3_s1",   1, 0, 8'hA2, 0, 4'b0010, 0, 0, 0, 32'h0000A2A1);
    step("f3_s2",   1, 0, 8'hA3, 0, 4'b0100, 0, 0, 0, 32'h00A3A2A1);
    step("f3_s3",   1, 0, 8'hA4, 0, 4'b1000, 1, 0, 0, 32'hA4A3A2A1);

`ifdef TDM_DEMUX_PARITY_EN
    step("pe_s0",   1, 1, 8'hB1, 0, 4'b0001, 0, 0, 0, 32'hA4A3A2B1);
    step("pe_s1",   1, 0, 8'hB2, 0, 4'b0010, 0, 0, 0, 32'hA4A3B2B1);
    step("pe_s2",   1, 0, 8'hB3, 1, 4'b0000, 0, 0, 1, 32'hA4A3B2B1);
    step("pe_s3",   1, 0, 8'hB4, 0, 4'b1000, 1, 0, 0, 32'hB4A3B2B1);
    step("pe_drop", 1, 0, 8'hC5, 1, 4'b0000, 0, 1, 0, 32'hB4A3B2B1);
`endif

    step("end_idle", 0, 0, 8'h00, 0, 4'b0000, 0, 0, 0,
`ifdef TDM_DEMUX_PARITY_EN
         32'hB4A3B2B1);
`else
         32'hA4A3A2A1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
